countdown_timer: RTL and testbench

//  Loadable down-counter: the count-down counterpart to the free-running up counter.
//  A load handshake starts it. It decrements on each enabled cycle and pulses expire on

---
 rtl/countdown_timer_pkg.sv | 7 +
 rtl/sat_counter.sv | 19 +
 rtl/countdown_timer.sv | 92 +++++++++
 tb/tb_countdown_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared FSM encodings for the countdown timer and anything that decodes its state.
package countdown_timer_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds once it reaches all-ones.
module sat_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or periodic reload, expire pulse and a
// saturating expiry count.
import countdown_timer_pkg::*;

module countdown_timer #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [WIDTH-1:0]     load_value,
   input  logic                 auto_reload,
   input  logic                 enable,
   input  logic                 abort,
   output logic [WIDTH-1:0]     q,
   output logic                 busy,
   output logic                 expire,
   output logic [CNT_WIDTH-1:0] expire_cnt
);

   logic [0:0]       state;
   logic [WIDTH-1:0] reload_reg;
   logic             arl;
   logic             accept;
   logic             hit;

   assign load_ready = (state == ST_IDLE) && !abort;
   assign accept     = load_valid && load_ready;
   assign busy       = (state == ST_RUN);

   // Terminal count: either a zero-length load or the last enabled cycle of a run.
   // Abort wins over terminal count, so it masks hit in RUN.
   always_comb begin
      hit = 1'b0;
      if (state == ST_IDLE) begin
         hit = accept && (load_value == '0);
      end else begin
         hit = !abort && enable && (q == WIDTH'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         q          <= '0;
         reload_reg <= '0;
         arl        <= 1'b0;
         expire     <= 1'b0;
      end else begin
         expire <= hit;
         case (state)
            ST_IDLE: begin
               if (accept && (load_value != '0)) begin
                  q          <= load_value;
                  reload_reg <= load_value;
                  arl        <= auto_reload;
                  state      <= ST_RUN;
               end
            end
            default: begin
               if (abort) begin
                  q     <= '0;
                  state <= ST_IDLE;
               end else if (enable) begin
                  if (q == WIDTH'(1)) begin
                     if (arl) begin
                        q <= reload_reg;
                     end else begin
                        q     <= '0;
                        state <= ST_IDLE;
                     end
                  end else begin
                     q <= q - WIDTH'(1);
                  end
               end
            end
         endcase
      end
   end

   sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_expire_cnt (
      .clk(clk),
      .rst(rst),
      .inc(hit),
      .cnt(expire_cnt)
   );

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a cycle model pushes expected outputs at drive
// time; they are popped and compared after each rising edge.
module tb_countdown_timer;

   typedef struct packed {
      logic [7:0] q;
      logic       busy;
      logic       expire;
      logic [7:0] cnt;
      logic [1:0] cnt2;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_value = 8'd0;
   logic       auto_reload = 1'b0;
   logic       enable = 1'b0;
   logic       abort = 1'b0;

   logic       load_ready, busy, expire;
   logic [7:0] q, expire_cnt;
   logic       s_ready, s_busy, s_expire;
   logic [7:0] s_q;
   logic [1:0] s_cnt;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_miss = 0;

   logic [7:0] m_q = 8'd0, m_rel = 8'd0;
   logic       m_busy = 1'b0, m_arl = 1'b0, m_known = 1'b0;
   logic [7:0] m_cnt = 8'd0;
   logic [1:0] m_cnt2 = 2'd0;

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(8), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_value(load_value), .auto_reload(auto_reload), .enable(enable), .abort(abort),
      .q(q), .busy(busy), .expire(expire), .expire_cnt(expire_cnt)
   );

   countdown_timer #(.WIDTH(8), .CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(s_ready),
      .load_value(load_value), .auto_reload(auto_reload), .enable(enable), .abort(abort),
      .q(s_q), .busy(s_busy), .expire(s_expire), .expire_cnt(s_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic lv, input logic [7:0] lval,
                       input logic ar, input logic en, input logic ab);
      exp_t e;
      logic hit;
      @(negedge clk);
      rst = r; load_valid = lv; load_value = lval;
      auto_reload = ar; enable = en; abort = ab;
      #1;
      if (m_known && !r) begin
         check_val("load_ready", {31'd0, load_ready}, {31'd0, (!m_busy && !ab)});
      end
      hit = 1'b0;
      if (r) begin
         m_q = 8'd0; m_rel = 8'd0; m_arl = 1'b0; m_busy = 1'b0;
         m_cnt = 8'd0; m_cnt2 = 2'd0;
      end else if (!m_busy) begin
         if (lv && !ab) begin
            if (lval != 8'd0) begin
               m_q = lval; m_rel = lval; m_arl = ar; m_busy = 1'b1;
            end else begin
               hit = 1'b1;
            end
         end
      end else if (ab) begin
         m_busy = 1'b0; m_q = 8'd0;
      end else if (en) begin
         if (m_q == 8'd1) begin
            hit = 1'b1;
            if (m_arl) m_q = m_rel;
            else begin
               m_q = 8'd0; m_busy = 1'b0;
            end
         end else begin
            m_q = m_q - 8'd1;
         end
      end
      if (hit) begin
         if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
         if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
      e.q = m_q; e.busy = m_busy; e.expire = hit; e.cnt = m_cnt; e.cnt2 = m_cnt2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      m_known = 1'b1;
      e = sb.pop_front();
      check_val("q", {24'd0, q}, {24'd0, e.q});
      check_val("busy", {31'd0, busy}, {31'd0, e.busy});
      check_val("expire", {31'd0, expire}, {31'd0, e.expire});
      check_val("expire_cnt", {24'd0, expire_cnt}, {24'd0, e.cnt});
      check_val("sat_expire", {31'd0, s_expire}, {31'd0, e.expire});
      check_val("sat_cnt", {30'd0, s_cnt}, {30'd0, e.cnt2});
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int pulses;
      int zero_busy;
      logic [7:0] qs [6];
      logic [1:0] sat_seq [5];
      logic [1:0] sat_exp [5];
      logic       en_bit;

      // Reset with a pending load request that must not be taken.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0);
      check_val("rst_q", {24'd0, q}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_cnt", {24'd0, expire_cnt}, 32'd0);

      // One-shot load of 5.
      step(1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
      qs[0] = q;
      pulses = 0;
      for (int i = 1; i < 6; i++) begin
         step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
         qs[i] = q;
         if (expire) pulses++;
         if (i == 5) check_val("oneshot_exp_at5", {31'd0, expire}, 32'd1);
      end
      for (int i = 0; i < 6; i++) check_val("oneshot_q_seq", {24'd0, qs[i]}, 32'(5 - i));
      check_val("oneshot_pulses", pulses, 32'd1);
      check_val("oneshot_cnt", {24'd0, expire_cnt}, 32'd1);
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      check_val("oneshot_idle_ready", {31'd0, load_ready}, 32'd1);

      // Periodic load of 3 with enable toggling.
      do_reset();
      step(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
      pulses = 0;
      zero_busy = 0;
      for (int i = 0; i < 24; i++) begin
         en_bit = (i % 2 == 0);
         step(1'b0, 1'b0, 8'd0, 1'b0, en_bit, 1'b0);
         if (expire) pulses++;
         if (busy && q == 8'd0) zero_busy++;
      end
      check_val("periodic_pulses", pulses, 32'd4);
      check_val("periodic_cnt", {24'd0, expire_cnt}, 32'd4);
      check_val("periodic_no_zero", zero_busy, 32'd0);
      check_val("periodic_q_reload", {24'd0, q}, 32'd3);
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

      // Abort on the terminal-count cycle, with a competing load request.
      do_reset();
      step(1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'd6, 1'b0, 1'b1, 1'b1);
      check_val("abort_q", {24'd0, q}, 32'd0);
      check_val("abort_no_exp", {31'd0, expire}, 32'd0);
      check_val("abort_cnt", {24'd0, expire_cnt}, 32'd0);
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      check_val("abort_no_load", {31'd0, busy}, 32'd0);

      // Zero-length load, then a load attempted mid-count.
      do_reset();
      step(1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
      check_val("zero_exp", {31'd0, expire}, 32'd1);
      check_val("zero_busy", {31'd0, busy}, 32'd0);
      step(1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
      check_val("runload_ignored", {24'd0, q}, 32'd3);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      check_val("runload_done_cnt", {24'd0, expire_cnt}, 32'd2);

      // Saturation of the 2-bit counter over five one-shot loads of 1.
      do_reset();
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
      sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
         sat_seq[i] = s_cnt;
         check_val("sat_pulse", {31'd0, s_expire}, 32'd1);
      end
      for (int i = 0; i < 5; i++) check_val("sat_seq", {30'd0, sat_seq[i]}, {30'd0, sat_exp[i]});

      // Full-scale load value.
      do_reset();
      step(1'b0, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0);
      pulses = 0;
      for (int i = 0; i < 255; i++) begin
         step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
         if (expire) pulses++;
      end
      check_val("max_pulse_last", {31'd0, expire}, 32'd1);
      check_val("max_pulses", pulses, 32'd1);

      // Random traffic, including resets in RUN.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
              8'($urandom_range(0, 6)), $urandom_range(0, 1),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
